// File: rtl/axis_dump_recorder_pkg.sv
// Shared definitions for the AXI-Stream dump recorder: FSM encoding and the
// layout of one dump entry {tvalid, tlast, tuser, tkeep, tdata}.
package axis_dump_recorder_pkg;

    localparam int DEF_DATA_WIDTH  = 512;
    localparam int DEF_TUSER_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH  = 17;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOP = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_TERM     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Field offsets within an entry; tdata always sits at bit 0.
    localparam int OFF_TDATA = 0;

    function automatic int entry_width(input int dw, input int uw);
        return 2 + uw + dw / 8 + dw;
    endfunction

    function automatic int off_tkeep(input int dw);
        return dw;
    endfunction

    function automatic int off_tuser(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int off_tlast(input int dw, input int uw);
        return dw + dw / 8 + uw;
    endfunction

    function automatic int off_tvalid(input int dw, input int uw);
        return dw + dw / 8 + uw + 1;
    endfunction

endpackage

// File: rtl/axis_dump_recorder_dump_ram.sv
// Simple dual-port RAM holding dump entries: one write port, one registered
// read port. A read of the address being written returns the old content.
module axis_dump_recorder_dump_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Both accesses use non-blocking updates, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_dump_recorder.sv
// Captures AXI-Stream packets into a dump memory on packet boundaries and
// terminates the image with a tvalid=0 entry; the image is readable via rd_*.
module axis_dump_recorder
    import axis_dump_recorder_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
    input  logic                          axis_aclk,
    input  logic                          axis_rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          arm,
    input  logic                          stop,
    output logic                          armed,
    output logic                          done,
    output logic                          truncated,
    output logic [ADDR_WIDTH-1:0]         beat_count,
    output logic [ADDR_WIDTH-1:0]         pkt_count,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_valid,
    output logic                          rd_tvalid,
    output logic                          rd_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]    rd_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  rd_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   rd_tuser
);

    localparam int DW = AXIS_DATA_WIDTH;
    localparam int KW = AXIS_DATA_WIDTH / 8;
    localparam int UW = AXIS_TUSER_WIDTH;
    localparam int EW = entry_width(DW, UW);

    // Last address that may hold data; the one above it is kept for the terminator.
    localparam logic [ADDR_WIDTH-1:0] LAST_DATA_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [ADDR_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic                  truncated_q, truncated_d;
    logic                  stop_req_q, stop_req_d;
    logic                  in_pkt_q;
    logic                  tready_q;
    logic                  rd_valid_q;

    logic                  hs;
    logic                  in_pkt_after;
    logic                  at_full;
    logic                  stored_tlast;
    logic                  ram_wr_en;
    logic [EW-1:0]         ram_wr_data;
    logic [EW-1:0]         ram_rd_data;

    assign hs           = s_axis_tvalid & tready_q;
    assign in_pkt_after = hs ? ~s_axis_tlast : in_pkt_q;
    assign at_full      = (wr_addr_q == LAST_DATA_ADDR);
    assign stored_tlast = s_axis_tlast | at_full;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        truncated_d  = truncated_q;
        stop_req_d   = stop_req_q;
        ram_wr_en    = 1'b0;
        ram_wr_data  = {1'b1, stored_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d      = ST_WAIT_SOP;
                    wr_addr_d    = '0;
                    beat_count_d = '0;
                    pkt_count_d  = '0;
                    truncated_d  = 1'b0;
                    stop_req_d   = 1'b0;
                end
            end
            ST_WAIT_SOP: begin
                // A packet start wins over a simultaneous stop; the stop then
                // closes the capture at the end of that packet.
                if (hs && !in_pkt_q) begin
                    ram_wr_en    = 1'b1;
                    wr_addr_d    = wr_addr_q + 1'b1;
                    beat_count_d = beat_count_q + 1'b1;
                    if (s_axis_tlast) begin
                        pkt_count_d = pkt_count_q + 1'b1;
                    end
                    stop_req_d = stop;
                    state_d    = (stop && s_axis_tlast) ? ST_TERM : ST_CAPTURE;
                end else if (stop) begin
                    state_d   = ST_TERM;
                    wr_addr_d = '0;
                end
            end
            ST_CAPTURE: begin
                stop_req_d = stop_req_q | stop;
                if (hs) begin
                    ram_wr_en    = 1'b1;
                    wr_addr_d    = wr_addr_q + 1'b1;
                    beat_count_d = beat_count_q + 1'b1;
                    if (stored_tlast) begin
                        pkt_count_d = pkt_count_q + 1'b1;
                    end
                    if (at_full && !s_axis_tlast) begin
                        truncated_d = 1'b1;
                    end
                end
                if (hs && at_full) begin
                    state_d = ST_TERM;
                end else if (stop_req_d && !in_pkt_after) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                ram_wr_en   = 1'b1;
                ram_wr_data = '0;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
            truncated_q  <= 1'b0;
            stop_req_q   <= 1'b0;
            in_pkt_q     <= 1'b0;
            tready_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
            truncated_q  <= truncated_d;
            stop_req_q   <= stop_req_d;
            in_pkt_q     <= in_pkt_after;
            tready_q     <= 1'b1;
            rd_valid_q   <= rd_en;
        end
    end

    axis_dump_recorder_dump_ram #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (ADDR_WIDTH)
    ) u_dump_ram (
        .clk     (axis_aclk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (ram_wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign s_axis_tready = tready_q;
    assign armed         = (state_q == ST_WAIT_SOP) || (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign truncated     = truncated_q;
    assign beat_count    = beat_count_q;
    assign pkt_count     = pkt_count_q;
    assign rd_valid      = rd_valid_q;

    assign rd_tdata  = ram_rd_data[OFF_TDATA +: DW];
    assign rd_tkeep  = ram_rd_data[off_tkeep(DW) +: KW];
    assign rd_tuser  = ram_rd_data[off_tuser(DW) +: UW];
    assign rd_tlast  = ram_rd_data[off_tlast(DW, UW)];
    assign rd_tvalid = ram_rd_data[off_tvalid(DW, UW)];

endmodule

// File: tb/tb_axis_dump_recorder.sv
// Self-checking bench for axis_dump_recorder: table-driven capture scenarios,
// hand-written corner sequences, and a queue of expected memory entries.
module tb_axis_dump_recorder;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;
    localparam int AW = 4;
    localparam int EW = 2 + UW + KW + DW;

    logic          clk = 1'b0;
    logic          axis_rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          arm, stop;
    logic          armed, done, truncated;
    logic [AW-1:0] beat_count, pkt_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid, rd_tvalid, rd_tlast;
    logic [DW-1:0] rd_tdata;
    logic [KW-1:0] rd_tkeep;
    logic [UW-1:0] rd_tuser;

    always #5 clk = ~clk;

    axis_dump_recorder #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .ADDR_WIDTH       (AW)
    ) dut (
        .axis_aclk     (clk),
        .axis_rst      (axis_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .arm           (arm),
        .stop          (stop),
        .armed         (armed),
        .done          (done),
        .truncated     (truncated),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_tvalid     (rd_tvalid),
        .rd_tlast      (rd_tlast),
        .rd_tdata      (rd_tdata),
        .rd_tkeep      (rd_tkeep),
        .rd_tuser      (rd_tuser)
    );

    typedef struct {
        logic        arm;
        logic        stop;
        logic        valid;
        logic        last;
        logic [31:0] data;
        int          exp_addr;   // -1: nothing expected in memory from this cycle
        logic        exp_term;   // expected entry is the all-zero terminator
        logic        chk;        // compare status outputs after this cycle
        logic        exp_done;
        int          exp_beats;
        int          exp_pkts;
    } row_t;

    typedef struct {
        int            addr;
        logic [EW-1:0] entry;
    } exp_t;

    row_t tbl[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [EW-1:0] mk_entry(input logic v, input logic l, input logic [DW-1:0] d);
        return {v, l, d[7:0] ^ 8'hA5, d[11:8], d};
    endfunction

    function automatic row_t mkrow(input logic a, input logic s, input logic v, input logic l,
                                   input logic [31:0] d, input int ea, input logic et,
                                   input logic c, input logic ed, input int eb, input int ep);
        row_t r;
        r.arm = a; r.stop = s; r.valid = v; r.last = l; r.data = d;
        r.exp_addr = ea; r.exp_term = et; r.chk = c;
        r.exp_done = ed; r.exp_beats = eb; r.exp_pkts = ep;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [DW-1:0] d);
        s_axis_tvalid = v;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
        s_axis_tuser  = d[7:0] ^ 8'hA5;
        s_axis_tkeep  = d[11:8];
    endtask

    task automatic idle_inputs();
        arm  = 1'b0;
        stop = 1'b0;
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic push_exp(input int addr, input logic [EW-1:0] entry);
        exp_t e;
        e.addr  = addr;
        e.entry = entry;
        exp_q.push_back(e);
    endtask

    task automatic apply(input row_t r);
        arm  = r.arm;
        stop = r.stop;
        drive(r.valid, r.last, r.data);
        if (r.exp_addr >= 0) begin
            push_exp(r.exp_addr, r.exp_term ? '0 : mk_entry(1'b1, r.last, r.data));
        end
        tick();
        idle_inputs();
        if (r.chk) begin
            chk("done", 64'(done), 64'(r.exp_done));
            chk("beat_count", 64'(beat_count), 64'(r.exp_beats));
            chk("pkt_count", 64'(pkt_count), 64'(r.exp_pkts));
        end
    endtask

    // Drain the scoreboard through the read port: one read transaction per entry.
    task automatic check_mem();
        exp_t          e;
        logic [EW-1:0] act;
        while (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            rd_en   = 1'b1;
            rd_addr = e.addr[AW-1:0];
            tick();
            rd_en   = 1'b0;
            act     = {rd_tvalid, rd_tlast, rd_tuser, rd_tkeep, rd_tdata};
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk($sformatf("entry[%0d]", e.addr), 64'(act), 64'(e.entry));
            $display("read addr=%0d entry=%h", e.addr, act);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end
        tbl.delete();
        check_mem();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst = 1'b1;
        rd_en    = 1'b0;
        rd_addr  = '0;
        idle_inputs();
        repeat (3) tick();

        chk("rst tready", 64'(s_axis_tready), 64'd0);
        chk("rst armed", 64'(armed), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst truncated", 64'(truncated), 64'd0);
        chk("rst beat_count", 64'(beat_count), 64'd0);
        chk("rst pkt_count", 64'(pkt_count), 64'd0);
        chk("rst rd_valid", 64'(rd_valid), 64'd0);
        axis_rst = 1'b0;
        repeat (2) tick();
        chk("tready after rst", 64'(s_axis_tready), 64'd1);

        // Packets of 2, 1 and 4 beats, then stop at a boundary.
        tbl.push_back(mkrow(1, 0, 0, 0, 32'h0,   -1, 0, 1, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'h100,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'h201,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'h302,  2, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'h403,  3, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'h504,  4, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'h605,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'h706,  6, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 1, 0, 0, 32'h0,   -1, 0, 1, 0, 7, 3));
        tbl.push_back(mkrow(0, 0, 0, 0, 32'h0,    7, 1, 1, 1, 7, 3));
        run_table();

        // Arm in the middle of a packet: its tail is skipped, next packet lands at 0.
        tbl.push_back(mkrow(0, 0, 1, 0, 32'h820, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(1, 0, 1, 0, 32'h921, -1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'hA22, -1, 0, 1, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'hB23,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'hC24,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 1, 0, 0, 32'h0,   -1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 0, 0, 32'h0,    2, 1, 1, 1, 2, 1));
        run_table();

        // Stop on the first beat of a 3-beat packet: the whole packet is kept.
        tbl.push_back(mkrow(1, 0, 0, 0, 32'h0,   -1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 1, 1, 0, 32'hD30,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 0, 32'hE31,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mkrow(0, 0, 1, 1, 32'hF32,  2, 0, 1, 0, 3, 1));
        tbl.push_back(mkrow(0, 0, 0, 0, 32'h0,    3, 1, 1, 1, 3, 1));
        run_table();

        // Stop while waiting for a packet start with no traffic.
        arm = 1'b1;
        tick();
        idle_inputs();
        chk("wait armed", 64'(armed), 64'd1);
        stop = 1'b1;
        tick();
        idle_inputs();
        chk("term done", 64'(done), 64'd0);
        tick();
        chk("empty done", 64'(done), 64'd1);
        chk("empty beat_count", 64'(beat_count), 64'd0);
        push_exp(0, '0);
        check_mem();

        // One 20-beat packet into a 16-entry memory: truncated at entry 14.
        arm = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i == 19, 32'h1000 + 32'(i) * 32'h111);
            if (i <= 14) begin
                push_exp(i, mk_entry(1'b1, i == 14, 32'h1000 + 32'(i) * 32'h111));
            end
            tick();
        end
        idle_inputs();
        push_exp(15, '0);
        chk("full truncated", 64'(truncated), 64'd1);
        chk("full pkt_count", 64'(pkt_count), 64'd1);
        chk("full beat_count", 64'(beat_count), 64'd15);
        chk("full done", 64'(done), 64'd1);
        check_mem();

        // Reset mid-capture: state clears, memory contents persist.
        arm = 1'b1;
        tick();
        idle_inputs();
        chk("rearm truncated", 64'(truncated), 64'd0);
        chk("rearm armed", 64'(armed), 64'd1);
        drive(1'b1, 1'b0, 32'h5A50);
        tick();
        drive(1'b1, 1'b0, 32'h6B51);
        tick();
        idle_inputs();
        chk("mid beat_count", 64'(beat_count), 64'd2);
        axis_rst = 1'b1;
        tick();
        chk("midrst armed", 64'(armed), 64'd0);
        chk("midrst beat_count", 64'(beat_count), 64'd0);
        chk("midrst tready", 64'(s_axis_tready), 64'd0);
        axis_rst = 1'b0;
        tick();
        chk("postrst tready", 64'(s_axis_tready), 64'd1);
        push_exp(0, mk_entry(1'b1, 1'b0, 32'h5A50));
        push_exp(1, mk_entry(1'b1, 1'b0, 32'h6B51));
        check_mem();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
